// File: rtl/pnu_combiner_pkg.sv
// Shared op encodings and the per-op identity value for the masked channel reducer.
package pnu_combiner_pkg;

    localparam logic [1:0] OP_OR   = 2'd0;
    localparam logic [1:0] OP_AND  = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_XNOR = 2'd3;

    // Widest supported channel; callers cast the result down to their W.
    function automatic logic [63:0] op_identity(input logic [1:0] op);
        return (op == OP_AND) ? '1 : '0;
    endfunction

endpackage

// File: rtl/pnu_reduce_stage.sv
// Combinational N_CH x W bitwise reducer (OR/AND/XOR/XNOR) over packed channels.
module pnu_reduce_stage
    import pnu_combiner_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 8
) (
    input  logic [N_CH*W-1:0] data,
    input  logic [1:0]        op,
    output logic [W-1:0]      result
);

    logic [W-1:0] acc;

    always_comb begin
        acc = data[W-1:0];
        for (int unsigned k = 1; k < N_CH; k++) begin
            case (op)
                OP_OR:   acc = acc | data[k*W +: W];
                OP_AND:  acc = acc & data[k*W +: W];
                default: acc = acc ^ data[k*W +: W];
            endcase
        end
        // XNOR reduces as XOR then inverts once; disabled channels were fed zeros.
        result = (op == OP_XNOR) ? ~acc : acc;
    end

endmodule

// File: rtl/pnu_reduce_combiner.sv
// Two-stage valid/ready masked channel combiner.
// Optional out_parity output is enabled by defining PNU_REDUCE_PARITY_EN.
module pnu_reduce_combiner
    import pnu_combiner_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_mask,
    input  logic [1:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic              out_empty
`ifdef PNU_REDUCE_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    logic              s1_valid;
    logic [N_CH*W-1:0] s1_data;
    logic [1:0]        s1_op;
    logic              s1_empty;
    logic              s2_valid;
    logic [W-1:0]      s2_data;
    logic              s2_empty;

    logic              s2_free;
    logic              s1_adv;
    logic              in_fire;
    logic [W-1:0]      ident;
    logic [N_CH*W-1:0] masked;
    logic [W-1:0]      reduced;

    assign s2_free  = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !s1_valid || s1_adv;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        ident  = W'(op_identity(in_op));
        masked = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            masked[k*W +: W] = in_mask[k] ? in_data[k*W +: W] : ident;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_op    <= OP_OR;
            s1_empty <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_data  <= masked;
            s1_op    <= in_op;
            s1_empty <= (in_mask == '0);
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    pnu_reduce_stage #(
        .N_CH (N_CH),
        .W    (W)
    ) u_reduce (
        .data   (s1_data),
        .op     (s1_op),
        .result (reduced)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_empty <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_data  <= reduced;
            s2_empty <= s1_empty;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

`ifdef PNU_REDUCE_PARITY_EN
    logic s2_parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_parity <= 1'b0;
        end else if (s1_adv) begin
            s2_parity <= ^reduced;
        end
    end

    assign out_parity = s2_parity;
`endif

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_empty = s2_empty;

endmodule

// File: tb/tb_pnu_reduce_combiner.sv
// Bench for pnu_reduce_combiner: directed vectors, backpressure, reset mid-stall, random traffic.
module tb_pnu_reduce_combiner;

    localparam int unsigned N_CH = 4;
    localparam int unsigned W    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_mask;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_empty;
`ifdef PNU_REDUCE_PARITY_EN
    logic        out_parity;
`endif

    pnu_reduce_combiner #(
        .N_CH (N_CH),
        .W    (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_empty (out_empty)
`ifdef PNU_REDUCE_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [1:0]  op;
        logic [7:0]  exp_data;
        logic        exp_empty;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       e;
    } res_t;

    int   total = 0;
    int   passed = 0;
    res_t sb[$];
    logic prev_stall = 1'b0;
    logic [7:0] held_d;
    logic held_e;
    logic saw_not_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Per bit: count enabled channels with a 1 and apply the op's truth rule.
    function automatic res_t model(input logic [31:0] d, input logic [3:0] m, input logic [1:0] op);
        res_t r;
        for (int b = 0; b < 8; b++) begin
            int ones = 0;
            int en = 0;
            for (int k = 0; k < 4; k++) begin
                if (m[k]) begin
                    en++;
                    if (d[k*8+b]) ones++;
                end
            end
            case (op)
                2'd0: r.d[b] = (ones > 0);
                2'd1: r.d[b] = (ones == en);
                2'd2: r.d[b] = (ones % 2 == 1);
                default: r.d[b] = (ones % 2 == 0);
            endcase
        end
        r.e = (m == 4'h0);
        return r;
    endfunction

    // Single transfer into an idle pipeline with out_ready high; checks exact latency.
    task automatic send_and_check(input vec_t v);
        @(negedge clk);
        in_valid = 1'b1; in_data = v.data; in_mask = v.mask; in_op = v.op; out_ready = 1'b1;
        #1 chk({v.name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk({v.name, "_lat1_valid"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({v.name, "_valid"}, 64'(out_valid), 64'd1);
        chk({v.name, "_data"}, 64'(out_data), 64'(v.exp_data));
        chk({v.name, "_empty"}, 64'(out_empty), 64'(v.exp_empty));
`ifdef PNU_REDUCE_PARITY_EN
        chk({v.name, "_parity"}, 64'(out_parity), 64'(^v.exp_data));
`endif
    endtask

    // One clock of scoreboarded traffic; inputs driven on the falling edge.
    task automatic step(input logic iv, input logic [31:0] d, input logic [3:0] m,
                        input logic [1:0] op, input logic ordy, output logic acc);
        res_t exp;
        @(negedge clk);
        in_valid = iv; in_data = d; in_mask = m; in_op = op; out_ready = ordy;
        #1;
        if (prev_stall) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(held_d));
            chk("hold_empty", 64'(out_empty), 64'(held_e));
        end
        if (out_valid && sb.size() == 0) begin
            chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else if (out_valid && out_ready) begin
            exp = sb.pop_front();
            chk("stream_data", 64'(out_data), 64'(exp.d));
            chk("stream_empty", 64'(out_empty), 64'(exp.e));
        end
        acc = iv && in_ready;
        if (acc) sb.push_back(model(d, m, op));
        if (!in_ready) saw_not_ready = 1'b1;
        prev_stall = out_valid && !out_ready;
        held_d = out_data;
        held_e = out_empty;
    endtask

    initial begin
        vec_t vecs[6];
        logic acc;
        int sent;
        logic [31:0] rd;
        logic [3:0]  rm;
        logic [1:0]  rop;
        logic        rv;

        vecs[0] = '{"or_all",     {8'h01, 8'h02, 8'h04, 8'h80}, 4'hF,    2'd0, 8'h87, 1'b0};
        vecs[1] = '{"and_part",   {8'hFF, 8'h0F, 8'h3C, 8'h00}, 4'b1110, 2'd1, 8'h0C, 1'b0};
        vecs[2] = '{"xor_all",    {8'hAA, 8'h55, 8'hF0, 8'h0F}, 4'hF,    2'd2, 8'h00, 1'b0};
        vecs[3] = '{"xnor_all",   {8'hAA, 8'h55, 8'hF0, 8'h0F}, 4'hF,    2'd3, 8'hFF, 1'b0};
        vecs[4] = '{"and_empty",  {8'h12, 8'h34, 8'h56, 8'h78}, 4'h0,    2'd1, 8'hFF, 1'b1};
        vecs[5] = '{"or_empty",   {8'h12, 8'h34, 8'h56, 8'h78}, 4'h0,    2'd0, 8'h00, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; in_op = '0; out_ready = 1'b1;
        #23;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_empty", 64'(out_empty), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 6; i++) send_and_check(vecs[i]);

        // Backpressure: five transfers back-to-back, out_ready low in cycles 3..6.
        @(negedge clk);
        sb.delete(); prev_stall = 1'b0; saw_not_ready = 1'b0; sent = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            rd = {8'(cyc), 8'h11, 8'h22, 8'(8'h40 + sent)};
            step(sent < 5, rd, 4'b1011, 2'd2, !(cyc >= 3 && cyc <= 6), acc);
            if (acc) sent++;
        end
        chk("bp_all_sent", 64'(sent), 64'd5);
        chk("bp_in_ready_dropped", 64'(saw_not_ready), 64'd1);
        chk("bp_all_out", 64'(sb.size()), 64'd0);

        // Reset while a result is stalled at the output.
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_mask = 4'hF; in_op = 2'd0; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stall_valid", 64'(out_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        prev_stall = 1'b0; sb.delete();
        send_and_check('{"post_rst", {8'h0F, 8'hF0, 8'h00, 8'h00}, 4'b1100, 2'd2, 8'hFF, 1'b0});

        // Random traffic against the scoreboard; operands held until accepted.
        rv = 1'b0; rd = $urandom; rm = 4'($urandom); rop = 2'($urandom);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!rv || acc) begin
                rv = ($urandom_range(0, 3) != 0);
                rd = $urandom; rm = 4'($urandom); rop = 2'($urandom);
            end
            step(rv, rd, rm, rop, ($urandom_range(0, 3) != 0), acc);
        end
        for (int cyc = 0; cyc < 4; cyc++) step(1'b0, '0, '0, '0, 1'b1, acc);
        chk("rand_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
